// File: rtl/ls_mem_arbiter_pkg.sv
// Shared types for the IF/LS memory-port arbiter: FSM states, access sizes and requester IDs.
package ls_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_t;

endpackage

// File: rtl/ls_mem_arbiter_size_align.sv
// Natural-alignment check and read-data mask for one access size.
import ls_mem_arbiter_pkg::*;

module ls_size_align #(
  parameter int DW = 64
) (
  input  size_t          size,
  input  logic [2:0]     addr_lo,
  output logic           misalign,
  output logic [DW-1:0]  mask
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    misalign = 1'b0;
    mask     = '0;
    unique case (size)
      SZ_B: begin
        mask = DW'(8'hFF);
      end
      SZ_H: begin
        misalign = addr_lo[0];
        mask     = DW'(16'hFFFF);
      end
      SZ_W: begin
        misalign = addr_lo[1:0] != 2'b00;
        mask     = DW'(32'hFFFF_FFFF);
      end
      SZ_X: begin
        misalign = addr_lo != 3'b000;
        mask     = '1;
      end
    endcase
  end

endmodule

// File: rtl/ls_mem_arbiter.sv
// Arbitrates the single data-memory port between instruction fetch and the load/store unit,
// sequencing each access as IDLE -> BUSY (wait for ack or timeout) -> RESP (done pulse).
import ls_mem_arbiter_pkg::*;

module ls_mem_arbiter #(
  parameter int AW            = 64,
  parameter int DW            = 64,
  parameter int LS_STREAK_MAX = 4,
  parameter int TIMEOUT       = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [31:0]   if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [1:0]    ls_size,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_done,
  output logic [DW-1:0] ls_rdata,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [1:0]    mem_size,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  localparam int SW = $clog2(LS_STREAK_MAX + 1);

  state_t        state;
  req_id_t       owner;
  logic [SW-1:0] streak;
  logic [7:0]    tmo_cnt;

  logic          grant_ls;
  logic          grant_if;
  size_t         win_size;
  logic [AW-1:0] win_addr;
  logic          win_misalign;
  size_t         al_size;
  logic          al_misalign;
  logic [DW-1:0] al_mask;
  logic [DW-1:0] rd_masked;

  // LS has priority until it has won LS_STREAK_MAX times in a row against a waiting fetch.
  assign grant_ls = ls_req && (!if_req || (streak != SW'(LS_STREAK_MAX)));
  assign grant_if = if_req && !grant_ls;
  assign win_size = grant_ls ? size_t'(ls_size) : SZ_W;
  assign win_addr = grant_ls ? ls_addr : if_addr;

  // One checker serves both the IDLE alignment check and the BUSY capture mask.
  assign al_size = (state == ST_IDLE) ? win_size : size_t'(mem_size);

  ls_size_align #(.DW(DW)) u_align (
    .size     (al_size),
    .addr_lo  (win_addr[2:0]),
    .misalign (al_misalign),
    .mask     (al_mask)
  );

  // Size 10 is reserved for fetch; the LS port may not use it.
  assign win_misalign = al_misalign || (grant_ls && (ls_size == SZ_W));
  assign rd_masked    = mem_rdata & al_mask;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner     <= REQ_IF;
      streak    <= '0;
      tmo_cnt   <= '0;
      if_done   <= 1'b0;
      if_rdata  <= '0;
      ls_done   <= 1'b0;
      ls_rdata  <= '0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_size  <= '0;
      mem_wdata <= '0;
    end else begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
      err     <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (grant_ls || grant_if) begin
            owner  <= grant_ls ? REQ_LS : REQ_IF;
            streak <= (grant_ls && if_req) ? streak + 1'b1 : '0;
            if (win_misalign) begin
              state    <= ST_RESP;
              err      <= 1'b1;
              if_done  <= grant_if;
              ls_done  <= grant_ls;
              if_rdata <= '0;
              ls_rdata <= '0;
            end else begin
              state     <= ST_BUSY;
              mem_req   <= 1'b1;
              mem_we    <= grant_ls && ls_we;
              mem_addr  <= win_addr;
              mem_size  <= win_size;
              mem_wdata <= grant_ls ? ls_wdata : '0;
              tmo_cnt   <= '0;
            end
          end
        end
        ST_BUSY: begin
          if (mem_ack) begin
            state    <= ST_RESP;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            if_done  <= (owner == REQ_IF);
            ls_done  <= (owner == REQ_LS);
            if_rdata <= (owner == REQ_IF) ? rd_masked[31:0] : '0;
            ls_rdata <= (owner == REQ_LS && !mem_we) ? rd_masked : '0;
          end else if (tmo_cnt == 8'(TIMEOUT)) begin
            state    <= ST_RESP;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            err      <= 1'b1;
            if_done  <= (owner == REQ_IF);
            ls_done  <= (owner == REQ_LS);
            if_rdata <= '0;
            ls_rdata <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        ST_RESP: begin
          state    <= ST_IDLE;
          if_rdata <= '0;
          ls_rdata <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ls_mem_arbiter.sv
// Directed self-checking bench for ls_mem_arbiter: load, store, fairness, misalignment, timeout, reset.
module tb_ls_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [63:0] ls_addr;
  logic [1:0]  ls_size;
  logic [63:0] ls_wdata;
  logic        ls_done;
  logic [63:0] ls_rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [1:0]  mem_size;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;

  ls_mem_arbiter #(.AW(64), .DW(64), .LS_STREAK_MAX(4), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_size   (ls_size),
    .ls_wdata  (ls_wdata),
    .ls_done   (ls_done),
    .ls_rdata  (ls_rdata),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_size  (mem_size),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Acts as the memory: acks on the ack_after-th BUSY cycle (0 = never) and reports what it saw.
  task automatic do_access(input int ack_after, input logic [63:0] rd,
                           output int req_cycles, output int lat,
                           output logic d_if, output logic d_ls, output logic d_err,
                           output logic [63:0] r_ls, output logic [31:0] r_if,
                           output logic [1:0] sz, output logic we, output logic [63:0] addr);
    logic seen;
    seen = 1'b0;
    req_cycles = 0; lat = 0;
    d_if = 1'b0; d_ls = 1'b0; d_err = 1'b0;
    r_ls = '0; r_if = '0; sz = '0; we = 1'b0; addr = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      lat++;
      if (if_done || ls_done) begin
        seen = 1'b1;
        d_if = if_done; d_ls = ls_done; d_err = err;
        r_ls = ls_rdata; r_if = if_rdata;
        mem_ack = 1'b0;
        break;
      end
      if (mem_req) begin
        req_cycles++;
        if (req_cycles == 1) begin
          sz = mem_size; we = mem_we; addr = mem_addr;
        end
        mem_ack   = (req_cycles == ack_after);
        mem_rdata = rd;
      end else begin
        mem_ack = 1'b0;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
  endtask

  int          rc, lat;
  logic        d_if, d_ls, d_err, we;
  logic [63:0] r_ls, addr, rd;
  logic [31:0] r_if;
  logic [1:0]  sz;
  logic [5:0]  order;

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_size = 2'b00; ls_wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_if_done", 64'(if_done), 64'd0);
    check("rst_ls_done", 64'(ls_done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_ls_rdata", ls_rdata, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // mem_ack outside BUSY is ignored
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ack_no_req", 64'(mem_req), 64'd0);
      check("idle_ack_no_done", 64'(if_done | ls_done | err), 64'd0);
    end
    mem_ack = 1'b0;

    // LS byte load, ack on 2nd BUSY cycle
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b00; ls_addr = 64'h1000;
    do_access(2, 64'hFFFF_FFFF_FFFF_FFA5, rc, lat, d_if, d_ls, d_err, r_ls, r_if, sz, we, addr);
    ls_req = 1'b0;
    check("ldb_req_cycles", 64'(rc), 64'd2);
    check("ldb_latency", 64'(lat), 64'd3);
    check("ldb_ls_done", 64'(d_ls), 64'd1);
    check("ldb_if_done", 64'(d_if), 64'd0);
    check("ldb_err", 64'(d_err), 64'd0);
    check("ldb_rdata", r_ls, 64'h0000_0000_0000_00A5);
    check("ldb_mem_addr", addr, 64'h1000);
    check("ldb_mem_size", 64'(sz), 64'd0);
    @(negedge clk);
    check("ldb_done_one_cycle", 64'(ls_done), 64'd0);

    // LS halfword load, immediate ack
    ls_req = 1'b1; ls_size = 2'b01; ls_addr = 64'h1002;
    do_access(1, 64'hFFFF_FFFF_FFFF_8001, rc, lat, d_if, d_ls, d_err, r_ls, r_if, sz, we, addr);
    ls_req = 1'b0;
    check("ldh_latency", 64'(lat), 64'd2);
    check("ldh_rdata", r_ls, 64'h0000_0000_0000_8001);
    check("ldh_err", 64'(d_err), 64'd0);
    @(negedge clk);

    // Store halfword: command held stable even as LS inputs change mid-access
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b01; ls_addr = 64'h2002; ls_wdata = 64'h1234;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("st_mem_req", 64'(mem_req), 64'd1);
      check("st_mem_we", 64'(mem_we), 64'd1);
      check("st_mem_size", 64'(mem_size), 64'd1);
      check("st_mem_addr", mem_addr, 64'h2002);
      check("st_mem_wdata", mem_wdata, 64'h1234);
      if (c == 1) begin
        ls_req = 1'b0; ls_wdata = 64'hDEAD_BEEF; ls_addr = 64'h3000;
      end
      if (c == 3) begin
        mem_ack = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    check("st_ls_done", 64'(ls_done), 64'd1);
    check("st_ls_rdata", ls_rdata, 64'd0);
    check("st_err", 64'(err), 64'd0);
    check("st_mem_req_low", 64'(mem_req), 64'd0);
    ls_we = 1'b0;
    @(negedge clk);

    // Misaligned LS doubleword store
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b11; ls_addr = 64'h1004;
    do_access(1, 64'h55, rc, lat, d_if, d_ls, d_err, r_ls, r_if, sz, we, addr);
    ls_req = 1'b0; ls_we = 1'b0;
    check("mis_x_req_cycles", 64'(rc), 64'd0);
    check("mis_x_latency", 64'(lat), 64'd1);
    check("mis_x_ls_done", 64'(d_ls), 64'd1);
    check("mis_x_err", 64'(d_err), 64'd1);
    check("mis_x_rdata", r_ls, 64'd0);
    @(negedge clk);

    // LS size 10 is illegal even when aligned
    ls_req = 1'b1; ls_size = 2'b10; ls_addr = 64'h1000;
    do_access(1, 64'h55, rc, lat, d_if, d_ls, d_err, r_ls, r_if, sz, we, addr);
    ls_req = 1'b0;
    check("mis_w_req_cycles", 64'(rc), 64'd0);
    check("mis_w_err", 64'(d_err), 64'd1);
    @(negedge clk);

    // Misaligned fetch
    if_req = 1'b1; if_addr = 64'h102;
    do_access(1, 64'h55, rc, lat, d_if, d_ls, d_err, r_ls, r_if, sz, we, addr);
    if_req = 1'b0;
    check("mis_if_req_cycles", 64'(rc), 64'd0);
    check("mis_if_done", 64'(d_if), 64'd1);
    check("mis_if_err", 64'(d_err), 64'd1);
    check("mis_if_rdata", 64'(r_if), 64'd0);
    @(negedge clk);

    // Contention: expected grant order LS LS LS LS IF LS (1 = LS)
    order = 6'b101111;
    if_req = 1'b1; if_addr = 64'h100;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b11; ls_addr = 64'h1008;
    for (int i = 0; i < 6; i++) begin
      rd = 64'hA5A5_0000_C0DE_0000 + 64'(i);
      do_access(1, rd, rc, lat, d_if, d_ls, d_err, r_ls, r_if, sz, we, addr);
      check($sformatf("fair_ls_%0d", i), 64'(d_ls), 64'(order[i]));
      check($sformatf("fair_if_%0d", i), 64'(d_if), 64'(!order[i]));
      if (order[i]) check($sformatf("fair_ls_rdata_%0d", i), r_ls, rd);
      else          check($sformatf("fair_if_rdata_%0d", i), 64'(r_if), 64'(rd[31:0]));
    end
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);

    // Fetch timeout: no ack, 16 BUSY cycles then done + err
    if_req = 1'b1; if_addr = 64'h104;
    do_access(0, 64'hFFFF_FFFF_FFFF_FFFF, rc, lat, d_if, d_ls, d_err, r_ls, r_if, sz, we, addr);
    if_req = 1'b0;
    check("tmo_req_cycles", 64'(rc), 64'd16);
    check("tmo_if_done", 64'(d_if), 64'd1);
    check("tmo_err", 64'(d_err), 64'd1);
    check("tmo_rdata", 64'(r_if), 64'd0);
    check("tmo_mem_size", 64'(sz), 64'd2);
    check("tmo_mem_we", 64'(we), 64'd0);
    check("tmo_mem_addr", addr, 64'h104);
    @(negedge clk);

    // Ack on the 16th BUSY cycle beats the timeout
    if_req = 1'b1; if_addr = 64'h108;
    do_access(16, 64'h0123_4567_89AB_CDEF, rc, lat, d_if, d_ls, d_err, r_ls, r_if, sz, we, addr);
    if_req = 1'b0;
    check("tmo_edge_req_cycles", 64'(rc), 64'd16);
    check("tmo_edge_if_done", 64'(d_if), 64'd1);
    check("tmo_edge_err", 64'(d_err), 64'd0);
    check("tmo_edge_rdata", 64'(r_if), 64'h89AB_CDEF);
    @(negedge clk);

    // Reset while BUSY
    if_req = 1'b1; if_addr = 64'h200;
    @(negedge clk);
    @(negedge clk);
    check("rstb_busy", 64'(mem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstb_mem_req_async", 64'(mem_req), 64'd0);
    check("rstb_mem_addr_async", mem_addr, 64'd0);
    if_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstb_no_done", 64'(if_done | ls_done | err), 64'd0);
      check("rstb_no_req", 64'(mem_req), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
